// File: rtl/pattern_gen_pkg.sv
// Shared constants and phase type for the Johnson-style pattern generator.
package pattern_gen_pkg;

  localparam int PG_WIDTH_DEF = 8;

  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_DRAIN = 1'b1
  } phase_t;

endpackage

// File: rtl/pattern_gen_phase_ctr.sv
// Step counter and FILL/DRAIN phase flag; strobes on the last step of each phase.
module pattern_gen_phase_ctr
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [CW-1:0] o_count,
  output phase_t        o_phase,
  output logic          o_phase_end
);

  logic [CW-1:0] r_count;
  phase_t        r_phase;
  logic          w_phase_end;

  // Out-of-range counts are unreachable but still treated as the final step.
  assign w_phase_end = (r_count >= CW'(WIDTH - 1));

  // Advance the step counter and toggle the phase at each phase end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_phase <= PH_FILL;
    end else if (w_phase_end) begin
      r_count <= '0;
      r_phase <= (r_phase == PH_FILL) ? PH_DRAIN : PH_FILL;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count     = r_count;
  assign o_phase     = r_phase;
  assign o_phase_end = w_phase_end;

endmodule

// File: rtl/pattern_gen.sv
// Free-running fill/drain pattern generator with period 2*WIDTH.
// Optional wrap pulse enabled by defining PATTERN_GEN_WRAP_PULSE_EN.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
`ifdef PATTERN_GEN_WRAP_PULSE_EN
  ,
  output logic             wrap
`endif
);

  localparam int CW = $clog2(WIDTH);

  // a, c and count keep their short names so they can be probed for debug.
  logic [WIDTH-1:0] a;
  phase_t           c;
  logic [CW-1:0]    count;
  logic             w_phase_end;

  pattern_gen_phase_ctr #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_phase_ctr (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .o_count     (count),
    .o_phase     (c),
    .o_phase_end (w_phase_end)
  );

  // Shift left, feeding ones while filling and zeros while draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0;
    end else begin
      a <= {a[WIDTH-2:0], (c == PH_FILL)};
    end
  end

  assign out = a;

`ifdef PATTERN_GEN_WRAP_PULSE_EN
  logic r_wrap;

  // Pulse on the edge that returns the pattern to all zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= (c == PH_DRAIN) && w_phase_end;
    end
  end

  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Randomized self-checking bench for pattern_gen at WIDTH=8 and WIDTH=4.
module tb_pattern_gen;

  logic       clk;
  logic       rst;
  logic [7:0] out8;
  logic [3:0] out4;
`ifdef PATTERN_GEN_WRAP_PULSE_EN
  logic       wrap8;
  logic       wrap4;
`endif

  int checks;
  int errors;
  int n;          // edges since the last reset release

  pattern_gen #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .out  (out8)
`ifdef PATTERN_GEN_WRAP_PULSE_EN
    ,
    .wrap (wrap8)
`endif
  );

  pattern_gen #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .out  (out4)
`ifdef PATTERN_GEN_WRAP_PULSE_EN
    ,
    .wrap (wrap4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Reference: k steps in, the pattern is k ones from the LSB (k<=w),
  // otherwise all ones with (k-w) zeros shifted in from the bottom.
  function automatic logic [31:0] exp_pat(input int w, input int steps);
    int          k;
    logic [31:0] full;
    k    = steps % (2 * w);
    full = (32'd1 << w) - 32'd1;
    if (k <= w) return (32'd1 << k) - 32'd1;
    else        return (full << (k - w)) & full;
  endfunction

  task automatic check_all();
    check("out8",   32'(out8),       exp_pat(8, n));
    check("c8",     32'(dut.c),      32'((n / 8) % 2));
    check("count8", 32'(dut.count),  32'(n % 8));
    check("out4",   32'(out4),       exp_pat(4, n));
    check("c4",     32'(dut4.c),     32'((n / 4) % 2));
    check("count4", 32'(dut4.count), 32'(n % 4));
`ifdef PATTERN_GEN_WRAP_PULSE_EN
    check("wrap8", 32'(wrap8), 32'((n > 0) && (n % 16 == 0)));
    check("wrap4", 32'(wrap4), 32'((n > 0) && (n % 8 == 0)));
`endif
  endtask

  task automatic run_edges(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Assert reset between edges, check the immediate clear, hold, then release.
  task automatic mid_reset(input int hold);
    #2;
    rst = 1'b0;
    n   = 0;
    #1;
    check("async_out8", 32'(out8), 32'h0);
    check("async_out4", 32'(out4), 32'h0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n      = 0;
    rst    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;

    // Two full periods plus a few edges: fill, drain, wrap, restart.
    run_edges(40);

    // Drop reset while out8 = 1F.
    mid_reset(2);
    run_edges(5);
    check("pre_rst_1F", 32'(out8), 32'h1F);
    mid_reset(3);
    run_edges(1);
    check("restart_01", 32'(out8), 32'h01);
    run_edges(20);

    for (int r = 0; r < 8; r++) begin
      mid_reset($urandom_range(1, 4));
      run_edges($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
